// File: rtl/game_key_debouncer_pkg.sv
// Shared configuration and types for the game key debouncer.
// Defining GAME_SIM_FAST shrinks the debounce and repeat timing for simulation.
package game_key_debouncer_pkg;

    localparam int DEF_KEY_ACTIVE_LOW = 1;
    localparam int DEF_CNT_W          = 20;

`ifdef GAME_SIM_FAST
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_REPEAT_DELAY    = 16;
    localparam int DEF_REPEAT_PERIOD   = 8;
`else
    localparam int DEF_DEBOUNCE_CYCLES = 65536;
    localparam int DEF_REPEAT_DELAY    = 8388608;
    localparam int DEF_REPEAT_PERIOD   = 2097152;
`endif

    typedef enum logic [1:0] {
        EV_NONE,
        EV_PRESS,
        EV_RELEASE,
        EV_REPEAT
    } key_event_e;

    // Pin level seen while the button is not pressed.
    function automatic logic inactive_level(input int active_low);
        return (active_low != 0);
    endfunction

endpackage

// File: rtl/game_sync2.sv
// Generic two-flop synchronizer for asynchronous board inputs.
// RESET_VAL sets the level both flops load during reset.
module game_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/game_key_debouncer.sv
// Push-button conditioner: synchronizer, debounce counter and registered press/release pulses.
// Define GAME_KEY_AUTOREPEAT_EN to add auto-repeat key_pressed pulses while the key is held.
module game_key_debouncer
    import game_key_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W,
    parameter int KEY_ACTIVE_LOW  = DEF_KEY_ACTIVE_LOW,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_raw,
    output logic key_level,
    output logic key_pressed,
    output logic key_released
);

    localparam logic             ACT_LOW  = inactive_level(KEY_ACTIVE_LOW);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) ||
        (REPEAT_PERIOD < 1) || (REPEAT_PERIOD > REPEAT_DELAY)) begin : g_bad_cfg
        $error("game_key_debouncer: illegal timing parameters");
    end

    logic             sync_q;
    logic             s;
    logic [CNT_W-1:0] cnt;
    logic             deb_fire;
    logic             rpt_fire;
    key_event_e       ev;

    game_sync2 #(
        .RESET_VAL(ACT_LOW)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (key_raw),
        .q      (sync_q)
    );

    assign s = sync_q ^ ACT_LOW;

    // A debounced edge outranks a repeat, so a release edge never carries a repeat pulse.
    always_comb begin
        deb_fire = (s != key_level) && (cnt == DEB_LAST);
        ev       = EV_NONE;
        if (deb_fire) begin
            ev = s ? EV_PRESS : EV_RELEASE;
        end else if (rpt_fire) begin
            ev = EV_REPEAT;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt          <= '0;
            key_level    <= 1'b0;
            key_pressed  <= 1'b0;
            key_released <= 1'b0;
        end else begin
            key_pressed  <= (ev == EV_PRESS) || (ev == EV_REPEAT);
            key_released <= (ev == EV_RELEASE);
            if (s == key_level) begin
                cnt <= '0;
            end else if (deb_fire) begin
                key_level <= s;
                cnt       <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

`ifdef GAME_KEY_AUTOREPEAT_EN
    // The repeat delay can exceed the debounce range, so this counter is sized for both.
    localparam int RPT_W = (CNT_W > $clog2(REPEAT_DELAY)) ? CNT_W : $clog2(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPT_W-1:0] rpt_cnt;

    assign rpt_fire = key_level && (rpt_cnt == RPT_LAST);

    // Reloading to DELAY-PERIOD lets one terminal compare serve both first and later repeats.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rpt_cnt <= '0;
        end else if (!key_level || deb_fire) begin
            rpt_cnt <= '0;
        end else if (rpt_fire) begin
            rpt_cnt <= RPT_RELOAD;
        end else begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

endmodule

// File: tb/tb_game_key_debouncer.sv
// Self-checking bench for game_key_debouncer: directed scenarios plus random key activity
// compared against a sliding-window reference model.
module tb_game_key_debouncer;

    localparam int D      = 4;
    localparam int DELAY  = 16;
    localparam int PERIOD = 8;

    logic clk = 1'b0;
    logic reset_n;
    logic key_raw;
    logic key_level;
    logic key_pressed;
    logic key_released;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_press_cyc = -1;
    int last_rel_cyc = -1;
    int dut_press_cnt = 0;
    int dut_rel_cnt = 0;

    logic m_pipe0, m_pipe1, m_level, exp_pressed, exp_released;
    logic win[$];
    int   hold_t;
    int   exp_press_cnt = 0;
    int   exp_rel_cnt = 0;

    always #5 clk = ~clk;

    game_key_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (20),
        .KEY_ACTIVE_LOW (1),
        .REPEAT_DELAY   (DELAY),
        .REPEAT_PERIOD  (PERIOD)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_raw     (key_raw),
        .key_level   (key_level),
        .key_pressed (key_pressed),
        .key_released(key_released)
    );

    task automatic model_reset();
        m_pipe0      = 1'b0;
        m_pipe1      = 1'b0;
        m_level      = 1'b0;
        exp_pressed  = 1'b0;
        exp_released = 1'b0;
        hold_t       = 0;
        win.delete();
    endtask

    // Level flips once the last D synchronized samples all disagree with it.
    task automatic model_edge(input logic raw);
        logic s;
        logic all_diff;
        s       = m_pipe1;
        m_pipe1 = m_pipe0;
        m_pipe0 = ~raw;
        win.push_back(s);
        if (win.size() > D) void'(win.pop_front());
        exp_pressed  = 1'b0;
        exp_released = 1'b0;
        all_diff = (win.size() == D);
        foreach (win[i]) if (win[i] == m_level) all_diff = 1'b0;
        if (all_diff) begin
            m_level = s;
            hold_t  = 0;
            if (s) begin
                exp_pressed = 1'b1;
                exp_press_cnt++;
            end else begin
                exp_released = 1'b1;
                exp_rel_cnt++;
            end
        end else if (m_level) begin
            hold_t++;
`ifdef GAME_KEY_AUTOREPEAT_EN
            if (hold_t >= DELAY && ((hold_t - DELAY) % PERIOD) == 0) begin
                exp_pressed = 1'b1;
                exp_press_cnt++;
            end
`endif
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_output();
        check_bit("key_level", key_level, m_level);
        check_bit("key_pressed", key_pressed, exp_pressed);
        check_bit("key_released", key_released, exp_released);
        check_bit("pulse_exclusive", key_pressed & key_released, 1'b0);
    endtask

    // Starts and ends at a falling clock edge; one model step per rising edge.
    task automatic apply_stimulus(input logic raw, input int n);
        repeat (n) begin
            key_raw = raw;
            @(posedge clk);
            cyc++;
            model_edge(raw);
            #1;
            if (key_pressed === 1'b1) begin
                dut_press_cnt++;
                last_press_cyc = cyc;
            end
            if (key_released === 1'b1) begin
                dut_rel_cnt++;
                last_rel_cyc = cyc;
            end
            check_output();
            @(negedge clk);
        end
    endtask

    task automatic apply_reset(input logic raw, input int n);
        key_raw = raw;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_output();
        repeat (n) @(negedge clk);
        check_output();
        reset_n = 1'b1;
    endtask

    initial begin
        int   base;
        int   p0;
        int   r0;
        logic bounce_seq[10];

        reset_n = 1'b0;
        key_raw = 1'b1;
        @(negedge clk);
        $display("[TB] reset and idle");
        apply_reset(1'b1, 3);
        apply_stimulus(1'b1, 3);

        $display("[TB] clean press");
        base = cyc; p0 = dut_press_cnt; r0 = dut_rel_cnt;
        apply_stimulus(1'b0, 10);
        check_int("press_latency", last_press_cyc - base, D + 2);
        check_int("press_count", dut_press_cnt - p0, 1);
        check_int("press_no_release", dut_rel_cnt - r0, 0);

        $display("[TB] clean release");
        base = cyc; p0 = dut_press_cnt;
        apply_stimulus(1'b1, 10);
        check_int("release_latency", last_rel_cyc - base, D + 2);
        check_int("release_no_press", dut_press_cnt - p0, 0);

        $display("[TB] glitches");
        p0 = dut_press_cnt; r0 = dut_rel_cnt;
        apply_stimulus(1'b0, D - 1);
        apply_stimulus(1'b1, 10);
        check_int("glitch_no_press", dut_press_cnt - p0, 0);
        check_int("glitch_no_release", dut_rel_cnt - r0, 0);
        p0 = dut_press_cnt;
        apply_stimulus(1'b0, D);
        apply_stimulus(1'b1, 12);
        check_int("min_press_count", dut_press_cnt - p0, 1);

        $display("[TB] bounce");
        bounce_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        base = cyc; p0 = dut_press_cnt;
        foreach (bounce_seq[i]) apply_stimulus(bounce_seq[i], 1);
        check_int("bounce_latency", last_press_cyc - base, 9);
        check_int("bounce_press_count", dut_press_cnt - p0, 1);
        apply_stimulus(1'b1, 10);

        $display("[TB] reset mid-count");
        p0 = dut_press_cnt;
        apply_stimulus(1'b0, 4);
        apply_reset(1'b1, 2);
        apply_stimulus(1'b1, 10);
        check_int("midcount_no_press", dut_press_cnt - p0, 0);

        $display("[TB] key held through reset");
        apply_stimulus(1'b0, 3);
        apply_reset(1'b0, 2);
        base = cyc; p0 = dut_press_cnt;
        apply_stimulus(1'b0, 10);
        check_int("held_reset_latency", last_press_cyc - base, D + 2);
        check_int("held_reset_count", dut_press_cnt - p0, 1);
        apply_stimulus(1'b1, 10);

        $display("[TB] long hold");
        p0 = dut_press_cnt; r0 = exp_press_cnt;
        apply_stimulus(1'b0, 60);
        apply_stimulus(1'b1, 12);
        check_int("long_hold_presses", dut_press_cnt - p0, exp_press_cnt - r0);

        $display("[TB] random activity");
        for (int seg = 0; seg < 40; seg++) begin
            apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 12)));
        end
        apply_stimulus(1'b1, 10);

        check_int("total_presses", dut_press_cnt, exp_press_cnt);
        check_int("total_releases", dut_rel_cnt, exp_rel_cnt);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
